// File: rtl/core_wb_bridge.sv
// Core req/ack data port to Wishbone classic single-master bridge.
// Optional bus-timeout termination is enabled by defining BRIDGE_TIMEOUT_EN.
module core_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wr_data_i,
  input  logic [3:0]  core_mask_i,
  input  logic        core_wr_en_i,
  input  logic        core_req_i,
  output logic [31:0] core_rd_data_o,
  output logic        core_ack_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        timeout_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state;

`ifdef BRIDGE_TIMEOUT_EN
  // Counter holds the number of ack-less BUS cycles already elapsed, so the
  // limit is hit in the TIMEOUT_CYCLES-th BUS cycle.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;
  logic [31:0] addr_q;
`else
  assign timeout_o  = 1'b0;
  assign err_addr_o = '0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      core_rd_data_o <= '0;
      core_ack_o     <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_sel_o       <= '0;
      wb_addr_o      <= '0;
      wb_data_o      <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      count          <= '0;
      addr_q         <= '0;
      timeout_o      <= 1'b0;
      err_addr_o     <= '0;
`endif
    end else begin
      core_ack_o <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      timeout_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (core_req_i) begin
            wb_addr_o <= {core_addr_i[31:2], 2'b00};
            wb_we_o   <= core_wr_en_i;
            wb_sel_o  <= core_wr_en_i ? core_mask_i : 4'b1111;
            wb_data_o <= core_wr_data_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
            addr_q    <= core_addr_i;
            count     <= '0;
`endif
            state     <= BUS;
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            core_rd_data_o <= wb_data_i;
            core_ack_o     <= 1'b1;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            state          <= RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (count == LIMIT) begin
            core_rd_data_o <= TIMEOUT_DATA;
            core_ack_o     <= 1'b1;
            timeout_o      <= 1'b1;
            err_addr_o     <= addr_q;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            state          <= RESP;
          end else begin
            count <= count + 16'd1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_bridge.sv
// Directed self-checking bench for core_wb_bridge (TIMEOUT_CYCLES = 8).
// Timeout scenarios are exercised when BRIDGE_TIMEOUT_EN is defined.
module tb_core_wb_bridge;

  logic        sys_clk;
  logic        rst_n;
  logic [31:0] core_addr_i;
  logic [31:0] core_wr_data_i;
  logic [3:0]  core_mask_i;
  logic        core_wr_en_i;
  logic        core_req_i;
  logic [31:0] core_rd_data_o;
  logic        core_ack_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        timeout_o;
  logic [31:0] err_addr_o;

  int vectors;
  int miscompares;

  core_wb_bridge #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .core_addr_i(core_addr_i), .core_wr_data_i(core_wr_data_i),
    .core_mask_i(core_mask_i), .core_wr_en_i(core_wr_en_i), .core_req_i(core_req_i),
    .core_rd_data_o(core_rd_data_o), .core_ack_o(core_ack_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .timeout_o(timeout_o), .err_addr_o(err_addr_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req_i = 1'b0; core_addr_i = '0; core_wr_data_i = '0;
    core_mask_i = '0; core_wr_en_i = 1'b0; wb_data_i = '0; wb_ack_i = 1'b0;
    #3;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 0000000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
    end
    vectors++;
    if ({wb_addr_o, wb_data_o, core_rd_data_o, err_addr_o} !== 128'h0) begin
      miscompares++; $display("FAIL reset_data: got %h %h %h %h expected all 0", wb_addr_o, wb_data_o, core_rd_data_o, err_addr_o);
    end
    vectors++;
    if ({core_ack_o, timeout_o} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ack: got %b expected 00", {core_ack_o, timeout_o});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int cyc;
    bit got;
    core_addr_i = 32'h0000_1006; core_wr_en_i = 1'b0; core_mask_i = 4'h0;
    core_wr_data_i = 32'h0; core_req_i = 1'b1;
    cyc = 1;
    tick(); cyc++;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) begin
      miscompares++; $display("FAIL read_ctl: got %b expected 110", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    vectors++;
    if (wb_addr_o !== 32'h0000_1004) begin
      miscompares++; $display("FAIL read_addr: got %h expected 00001004", wb_addr_o);
    end
    vectors++;
    if (wb_sel_o !== 4'hF) begin
      miscompares++; $display("FAIL read_sel: got %h expected f", wb_sel_o);
    end
    wb_ack_i = 1'b1; wb_data_i = 32'h1234_5678;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(); cyc++;
      if (core_ack_o === 1'b1) got = 1'b1;
    end
    wb_ack_i = 1'b0; core_req_i = 1'b0;
    vectors++;
    if (!got || cyc != 3) begin
      miscompares++; $display("FAIL read_latency: got %0d (ack seen %0d) expected 3", cyc, got);
    end
    vectors++;
    if (core_rd_data_o !== 32'h1234_5678 || wb_cyc_o !== 1'b0) begin
      miscompares++; $display("FAIL read_data: got %h cyc %b expected 12345678 cyc 0", core_rd_data_o, wb_cyc_o);
    end
    tick();
    vectors++;
    if (core_ack_o !== 1'b0) begin
      miscompares++; $display("FAIL read_ack_pulse: got %b expected 0", core_ack_o);
    end
  endtask

  // Write with four wait states; core inputs are scrambled during BUS.
  task automatic test_write_addr_change();
    int cyc;
    int bad;
    core_addr_i = 32'h0000_2008; core_wr_en_i = 1'b1; core_mask_i = 4'b0011;
    core_wr_data_i = 32'hCAFE_F00D; core_req_i = 1'b1;
    cyc = 1;
    tick(); cyc++;
    core_addr_i = 32'hFFFF_FFF0; core_wr_data_i = 32'h0; core_mask_i = 4'hC; core_wr_en_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b111_0011) bad++;
      if (wb_data_o !== 32'hCAFE_F00D) bad++;
      if (core_ack_o !== 1'b0) bad++;
      if (i == 4) wb_ack_i = 1'b1;
      tick(); cyc++;
    end
    wb_ack_i = 1'b0; core_req_i = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL write_bus_stable: got %0d bad samples expected 0", bad);
    end
    vectors++;
    if (core_ack_o !== 1'b1 || cyc != 7) begin
      miscompares++; $display("FAIL write_latency: ack %b at cycle %0d expected 1 at 7", core_ack_o, cyc);
    end
    vectors++;
    if (wb_addr_o !== 32'h0000_2008) begin
      miscompares++; $display("FAIL addr_change: got %h expected 00002008", wb_addr_o);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    wb_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (core_ack_o !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
    end
    wb_ack_i = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL stray_ack: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int acks, starts, bad_data, consec, last_ack, bad_period;
    logic prev_ack, prev_cyc;
    acks = 0; starts = 0; bad_data = 0; consec = 0; last_ack = -1; bad_period = 0;
    prev_ack = 1'b0; prev_cyc = 1'b0;
    core_addr_i = 32'h0000_0100; core_wr_en_i = 1'b0; core_req_i = 1'b1;
    wb_data_i = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (wb_cyc_o === 1'b1 && prev_cyc !== 1'b1) starts++;
      if (core_ack_o === 1'b1) begin
        acks++;
        if (prev_ack === 1'b1) consec++;
        if (core_rd_data_o !== 32'(k - 1)) bad_data++;
        if (last_ack >= 0 && k - last_ack != 3) bad_period++;
        last_ack = k;
      end
      prev_ack = core_ack_o; prev_cyc = wb_cyc_o;
      wb_ack_i = wb_cyc_o;
      wb_data_i = 32'(k);
      core_addr_i = core_addr_i + 32'd4;
    end
    core_req_i = 1'b0; wb_ack_i = 1'b0;
    vectors++;
    if (acks != 4 || starts != 4) begin
      miscompares++; $display("FAIL b2b_count: got acks %0d starts %0d expected 4 4", acks, starts);
    end
    vectors++;
    if (consec != 0 || bad_period != 0) begin
      miscompares++; $display("FAIL b2b_period: got consec %0d bad_period %0d expected 0 0", consec, bad_period);
    end
    vectors++;
    if (bad_data != 0) begin
      miscompares++; $display("FAIL b2b_data: got %0d bad reads expected 0", bad_data);
    end
    tick(); tick();
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    core_addr_i = 32'h0000_3000; core_wr_en_i = 1'b0; core_req_i = 1'b1;
    tick();
    bad = 0;
    for (int b = 1; b <= 8; b++) begin
      if (wb_cyc_o !== 1'b1 || core_ack_o !== 1'b0) bad++;
      tick();
    end
    core_req_i = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL timeout_bus: got %0d bad BUS cycles expected 0", bad);
    end
    vectors++;
    if ({wb_cyc_o, core_ack_o, timeout_o} !== 3'b011) begin
      miscompares++; $display("FAIL timeout_flags: got cyc/ack/to %b expected 011", {wb_cyc_o, core_ack_o, timeout_o});
    end
    vectors++;
    if (core_rd_data_o !== 32'hDEAD_BEEF || err_addr_o !== 32'h0000_3000) begin
      miscompares++; $display("FAIL timeout_data: got %h err %h expected deadbeef 00003000", core_rd_data_o, err_addr_o);
    end
    tick();
    vectors++;
    if (timeout_o !== 1'b0 || err_addr_o !== 32'h0000_3000) begin
      miscompares++; $display("FAIL timeout_sticky: got to %b err %h expected 0 00003000", timeout_o, err_addr_o);
    end
    core_addr_i = 32'h0000_4000; core_req_i = 1'b1;
    tick();
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) begin wb_ack_i = 1'b1; wb_data_i = 32'h55AA_55AA; end
      tick();
    end
    wb_ack_i = 1'b0; core_req_i = 1'b0;
    vectors++;
    if ({core_ack_o, timeout_o} !== 2'b10 || core_rd_data_o !== 32'h55AA_55AA) begin
      miscompares++; $display("FAIL ack_at_limit: got ack/to %b data %h expected 10 55aa55aa", {core_ack_o, timeout_o}, core_rd_data_o);
    end
    vectors++;
    if (err_addr_o !== 32'h0000_3000) begin
      miscompares++; $display("FAIL ack_at_limit_err: got %h expected 00003000", err_addr_o);
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    int bad;
    core_addr_i = 32'h0000_3000; core_wr_en_i = 1'b0; core_req_i = 1'b1;
    tick();
    bad = 0;
    for (int b = 1; b <= 20; b++) begin
      if (wb_cyc_o !== 1'b1 || core_ack_o !== 1'b0 || timeout_o !== 1'b0) bad++;
      if (b == 20) begin wb_ack_i = 1'b1; wb_data_i = 32'h0BAD_CAFE; end
      tick();
    end
    wb_ack_i = 1'b0; core_req_i = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL wait_forever: got %0d bad BUS cycles expected 0", bad);
    end
    vectors++;
    if ({core_ack_o, timeout_o} !== 2'b10 || core_rd_data_o !== 32'h0BAD_CAFE || err_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL long_wait_done: got ack/to %b data %h err %h expected 10 0badcafe 0", {core_ack_o, timeout_o}, core_rd_data_o, err_addr_o);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_access();
    int bad;
    bit got;
    core_addr_i = 32'h0000_5004; core_wr_en_i = 1'b0; core_req_i = 1'b1;
    tick();
    vectors++;
    if (wb_cyc_o !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: got cyc %b expected 1", wb_cyc_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      miscompares++; $display("FAIL rst_mid_async: got cyc/stb %b expected 00", {wb_cyc_o, wb_stb_o});
    end
    core_req_i = 1'b0;
    wb_ack_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (core_ack_o !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
    end
    rst_n = 1'b1; wb_ack_i = 1'b0;
    tick();
    if (core_ack_o !== 1'b0 || err_addr_o !== 32'h0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL rst_mid_no_ack: got %0d bad cycles expected 0", bad);
    end
    core_addr_i = 32'h0000_6000; core_req_i = 1'b1;
    tick();
    wb_ack_i = 1'b1; wb_data_i = 32'h7777_0001;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (core_ack_o === 1'b1) got = 1'b1;
    end
    wb_ack_i = 1'b0; core_req_i = 1'b0;
    vectors++;
    if (!got || core_rd_data_o !== 32'h7777_0001 || wb_addr_o !== 32'h0000_6000) begin
      miscompares++; $display("FAIL rst_mid_recover: got ack %0d data %h addr %h expected 1 77770001 00006000", got, core_rd_data_o, wb_addr_o);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_read();
    test_write_addr_change();
    test_stray_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/core_wb_bridge.md
# core_wb_bridge

Bridges the Kronos-style req/ack data port of a core to the single-master Wishbone classic port of the Controller (data_mem_* bus). Sits directly downstream of the core data interface and upstream of the Controller. Registers each core request, runs one Wishbone classic cycle, and returns read data with a one-cycle ack. Optionally terminates cycles when no slave ack arrives.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUS-state cycles before a forced termination (1..65535).
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access.
- sys_clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_addr_i  in  32  byte address from core.
- core_wr_data_i  in  32  write data.
- core_mask_i  in  4  byte-lane write mask.
- core_wr_en_i  in  1  1 = write, 0 = read.
- core_req_i  in  1  request, held high until core_ack_o.
- core_rd_data_o  out  32  read data, valid while core_ack_o = 1.
- core_ack_o  out  1  one-cycle completion pulse.
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  byte select.
- wb_addr_o  out  32  word-aligned address.
- wb_data_o  out  32  write data.
- wb_data_i  in  32  read data from Controller.
- wb_ack_i  in  1  slave ack.
- timeout_o  out  1  pulses with core_ack_o when the access timed out.
- err_addr_o  out  32  address of the most recent timed-out access (sticky).

## Operation
- States: IDLE, BUS, RESP.
- IDLE: core_req_i = 1 latches addr, wr_data, mask, wr_en into holding registers; next state BUS. core_req_i = 0 stays IDLE.
- BUS: wb_cyc_o = wb_stb_o = 1; wb_addr_o = {addr[31:2], 2'b00}; wb_we_o = latched wr_en; wb_sel_o = wr_en ? mask : 4'b1111; wb_data_o = latched wr_data. All Wishbone outputs come from registers and stay stable for the whole cycle. On wb_ack_i = 1: capture wb_data_i (reads; writes capture too, value ignored by core), deassert cyc/stb next edge, go RESP.
- RESP: core_ack_o = 1 for exactly one cycle, core_rd_data_o = captured data; next state IDLE unconditionally.
- Core inputs are ignored outside IDLE; changes to core_*_i after capture have no effect on the current access.
- The core drops or replaces core_req_i the cycle after core_ack_o; a new request is accepted in the IDLE cycle after RESP.
- Reset values: all wb_* outputs 0, core_ack_o 0, core_rd_data_o 0, timeout_o 0, err_addr_o 0, state IDLE.
- Reset asserted mid-access: wb_cyc_o/wb_stb_o drop asynchronously, the access is abandoned, no core_ack_o is issued.

## Timing
- Access latency from the IDLE sampling edge to the core_ack_o cycle: N + 2 cycles, where N = number of BUS cycles (N >= 1). A zero-wait slave (ack in the first BUS cycle) gives 3 cycles; back-to-back throughput is 1 access per 3 cycles.
- wb_ack_i is sampled only in BUS; an ack in IDLE or RESP is ignored.
- core_ack_o is never high in two consecutive cycles.

## Configuration
- BRIDGE_TIMEOUT_EN defined: 16-bit counter cleared on entry to BUS and incremented each BUS cycle without wb_ack_i. When the count reaches TIMEOUT_CYCLES with no ack: deassert cyc/stb, go RESP with core_rd_data_o = TIMEOUT_DATA and timeout_o = 1, and load err_addr_o with the latched address. An ack in the same cycle as the limit wins, and the access is normal.
- BRIDGE_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; timeout_o and err_addr_o are tied to 0.

## Test plan
- Read with ack in the first BUS cycle, addr 32'h0000_1006, wb_data_i 32'h1234_5678 -> wb_addr_o 32'h0000_1004, wb_sel_o 4'hF, wb_we_o 0; core_ack_o 3 cycles after sampling with core_rd_data_o 32'h1234_5678.
- Write, mask 4'b0011, data 32'hCAFE_F00D, ack after 4 wait cycles -> wb_sel_o 4'b0011, wb_we_o 1, wb_data_o stable for 5 BUS cycles; core_ack_o 7 cycles after sampling.
- Back-to-back reads with core_req_i held high -> exactly one core_ack_o per access, a 3-cycle period, and no duplicate Wishbone cycle.
- Change core_addr_i during BUS -> wb_addr_o unchanged until the access completes.
- With BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no ack -> cyc drops after 8 BUS cycles; core_ack_o = 1, timeout_o = 1, core_rd_data_o 32'hDEAD_BEEF, err_addr_o = access address. Ack exactly at count 8 -> normal completion, timeout_o 0.
- Assert rst_n = 0 during BUS -> wb_cyc_o/wb_stb_o 0 immediately, no core_ack_o; after release, the next request completes normally.
